// File: rtl/mux_pipe_stage.sv
// M-input, N-bit operand-select pipeline stage with valid/ready handshake.
// A two-entry skid buffer (main + skid) keeps in_ready purely registered.
module mux_pipe_stage #(
  parameter  int unsigned N    = 32,
  parameter  int unsigned M    = 4,
  localparam int unsigned SELW = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M*N-1:0]  in_data,
  input  logic [SELW-1:0] sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [N-1:0]    out_data,
  output logic            out_sel_err,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] skid_data;
  logic         skid_err;

  logic         accept;
  logic         pop;
  logic         load_main;
  logic         load_skid;
  logic         main_from_skid;

  logic [N-1:0] sel_word;
  logic         sel_err;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  // Input selection; out-of-range selects yield zero data with the error flag.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < M; k++) begin
      if (sel == SELW'(k)) begin
        sel_word = in_data[k*N +: N];
        sel_err  = 1'b0;
      end
    end
  end

  // Next-state and storage-steering decode.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins: drop everything, leave data registers untouched.
    if (flush) begin
      state_nxt      = EMPTY;
      main_from_skid = 1'b0;
    end
  end

  // State register; handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
    end
  end

  // Main and skid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_sel_err <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
    end else begin
      if (load_main) begin
        out_data    <= sel_word;
        out_sel_err <= sel_err;
      end else if (main_from_skid) begin
        out_data    <= skid_data;
        out_sel_err <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_word;
        skid_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed bench for mux_pipe_stage: a 4-input and a 3-input instance, N=8.
module tb_mux_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;

  // 4-input instance
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_sel_err;
  logic [7:0]  out_data;

  // 3-input instance
  logic [23:0] in_data3;
  logic [1:0]  sel3;
  logic        in_valid3, in_ready3, out_valid3, out_ready3, out_sel_err3;
  logic [7:0]  out_data3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_pipe_stage #(.N(8), .M(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe_stage #(.N(8), .M(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(1'b0), .out_data(out_data3),
    .out_sel_err(out_sel_err3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word on lane 0 of the 4-input instance.
  task automatic offer(input logic [7:0] w);
    in_data  = {24'h0, w};
    sel      = 2'd0;
    in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data3 = '0; sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
    #2;
    step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_err",   32'(out_sel_err), 32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);

    // Basic select, sel 0..3 back-to-back
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_w;
      exp_w = 32'h11 * (i + 1);
      sel = 2'(i);
      step();
      check("sel_data",  32'(out_data),  exp_w);
      check("sel_valid", 32'(out_valid), 32'd1);
      check("sel_ready", 32'(in_ready),  32'd1);
      check("sel_err",   32'(out_sel_err), 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold",  32'(out_data),  32'h44);

    // Backpressure / skid
    out_ready = 1'b0;
    offer(8'hA5); step();
    check("bp1_data",  32'(out_data), 32'hA5);
    check("bp1_ready", 32'(in_ready), 32'd1);
    offer(8'h5A); step();
    check("bp2_data",  32'(out_data), 32'hA5);
    check("bp2_ready", 32'(in_ready), 32'd0);
    offer(8'h77); step();
    check("bp3_data",  32'(out_data), 32'hA5);
    check("bp3_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_head", 32'(out_data), 32'hA5);
    step();
    check("bp_skid",   32'(out_data),  32'h5A);
    check("bp_valid",  32'(out_valid), 32'd1);
    check("bp_ready",  32'(in_ready),  32'd1);
    step();
    check("bp_empty",  32'(out_valid), 32'd0);
    check("bp_nodrop", 32'(out_data),  32'h5A);

    // Simultaneous accept + pop in ONE
    for (int i = 1; i <= 3; i++) begin
      offer(8'(i)); step();
      check("ovl_data",  32'(out_data),  32'(i));
      check("ovl_valid", 32'(out_valid), 32'd1);
      check("ovl_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0; step();
    check("ovl_empty", 32'(out_valid), 32'd0);

    // Flush from FULL with a word offered
    out_ready = 1'b0;
    offer(8'h10); step();
    offer(8'h20); step();
    check("fl_full", 32'(in_ready), 32'd0);
    offer(8'h99); flush = 1'b1; out_ready = 1'b1; step();
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    in_valid = 1'b0; step();
    check("fl_stay",  32'(out_valid), 32'd0);
    offer(8'h30); step();
    check("fl_next",  32'(out_data),  32'h30);
    in_valid = 1'b0; step();
    check("fl_drain", 32'(out_valid), 32'd0);

    // Reset mid-stream while FULL
    out_ready = 1'b0;
    offer(8'h40); step();
    offer(8'h50); step();
    check("mr_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check("mr_valid", 32'(out_valid),   32'd0);
    check("mr_data",  32'(out_data),    32'd0);
    check("mr_err",   32'(out_sel_err), 32'd0);
    check("mr_ready", 32'(in_ready),    32'd1);
    out_ready = 1'b1;
    offer(8'h60); step();
    check("mr_resume", 32'(out_data),  32'h60);
    check("mr_rvalid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; step();
    check("mr_empty",  32'(out_valid), 32'd0);

    // Out-of-range select on the 3-input instance
    in_data3 = {8'hCC, 8'hBB, 8'hAA};
    in_valid3 = 1'b1;
    sel3 = 2'd3; step();
    check("oor_data",  32'(out_data3),    32'd0);
    check("oor_err",   32'(out_sel_err3), 32'd1);
    check("oor_valid", 32'(out_valid3),   32'd1);
    sel3 = 2'd1; step();
    check("oor1_data", 32'(out_data3),    32'hBB);
    check("oor1_err",  32'(out_sel_err3), 32'd0);
    sel3 = 2'd2; step();
    check("oor2_data", 32'(out_data3),    32'hCC);
    in_valid3 = 1'b0; step();
    check("oor_empty", 32'(out_valid3),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
